// File: rtl/dump_frame_rx_pkg.sv
// Shared constants for the dump frame receiver: header byte, error codes and state encoding.
package dump_frame_rx_pkg;

  localparam logic [7:0] HEADER = 8'hA5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_COUNT    = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_WORD  = 2'd2;
  localparam state_t ST_CHECK = 2'd3;

endpackage

// File: rtl/dump_frame_rx_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and strobes expire once the limit is hit.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || !en) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // A coincident clr suppresses expiry, so a byte landing on the last cycle still counts as on time.
  assign expire = en && !clr && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dump_frame_rx.sv
// Reassembles header/count/words[/checksum] frames from a UART byte stream into 32-bit words.
// Optional checksum byte enabled by defining DUMP_FRAME_RX_CHECKSUM_EN.
module dump_frame_rx
  import dump_frame_rx_pkg::*;
#(
  parameter int MAX_WORDS      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_done_tick,
  input  logic [7:0]                   rx_data,
  output logic                         word_valid,
  output logic [31:0]                  word_data,
  output logic [$clog2(MAX_WORDS)-1:0] word_index,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic [1:0]                   err_code,
  output logic                         busy
);

  localparam int         IW    = $clog2(MAX_WORDS);
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  state_t        state;
  logic [7:0]    n_words;
  logic [1:0]    byte_cnt;
  logic [IW-1:0] word_cnt;
  logic [7:0]    checksum;
  logic [23:0]   asm_word;
  logic          expire;
  logic          last_word;

  assign busy      = (state != ST_IDLE);
  assign last_word = (8'(word_cnt) == n_words - 8'd1);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (rx_done_tick),
    .en    (busy),
    .expire(expire)
  );

  // NOTE: asynchronous reset clears every register here, including the word assembly and output data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      n_words    <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      checksum   <= '0;
      asm_word   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_index <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (expire) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= ST_IDLE;
      end else if (rx_done_tick) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_data == HEADER) state <= ST_COUNT;
          end
          ST_COUNT: begin
            if (rx_data == 8'd0 || rx_data > MAX_N) begin
              frame_err <= 1'b1;
              err_code  <= ERR_COUNT;
              state     <= ST_IDLE;
            end else begin
              n_words  <= rx_data;
              byte_cnt <= '0;
              word_cnt <= '0;
              checksum <= rx_data;
              state    <= ST_WORD;
            end
          end
          ST_WORD: begin
            checksum <= checksum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Bytes arrive LSB first, so the fourth byte lands on top of the three shifted in.
              word_valid <= 1'b1;
              word_data  <= {rx_data, asm_word};
              word_index <= word_cnt;
              word_cnt   <= word_cnt + 1'b1;
              if (last_word) begin
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
                state <= ST_CHECK;
`else
                frame_done <= 1'b1;
                state      <= ST_IDLE;
`endif
              end
            end else begin
              asm_word <= {rx_data, asm_word[23:8]};
            end
          end
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
          ST_CHECK: begin
            if (rx_data == checksum) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHECKSUM;
            end
            state <= ST_IDLE;
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dump_frame_rx.sv
// Self-checking bench for dump_frame_rx: frame-level reference model plus directed and random frames.
module tb_dump_frame_rx;

  localparam int MAXW = 32;
  localparam int TO   = 20;
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        word_valid;
  logic [31:0] word_data;
  logic [4:0]  word_index;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  dump_frame_rx #(
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_index  (word_index),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the bytes of the current frame and derives outputs from frame position.
  logic [7:0]  fq[$];
  bit          in_frame = 1'b0;
  int          gap = 0;
  logic        exp_wv = 1'b0, exp_fd = 1'b0, exp_fe = 1'b0;
  logic [31:0] exp_wd = '0;
  logic [4:0]  exp_wi = '0;
  logic [1:0]  exp_ec = '0;

  task automatic model_err(input logic [1:0] code);
    exp_fe   = 1'b1;
    exp_ec   = code;
    in_frame = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fq.delete();
      in_frame = 1'b0;
      gap = 0;
      exp_wv = 1'b0; exp_fd = 1'b0; exp_fe = 1'b0;
      exp_wd = '0; exp_wi = '0; exp_ec = '0;
    end else begin
      exp_wv = 1'b0; exp_fd = 1'b0; exp_fe = 1'b0;
      if (rx_done_tick) begin
        gap = 0;
        if (!in_frame) begin
          if (rx_data == 8'hA5) begin
            in_frame = 1'b1;
            fq.delete();
          end
        end else begin
          int n, p;
          logic [7:0] cs;
          fq.push_back(rx_data);
          n = int'(fq[0]);
          if (fq.size() == 1) begin
            if (n == 0 || n > MAXW) model_err(2'b01);
          end else begin
            p = fq.size() - 2;
            if (p < 4 * n) begin
              if (p % 4 == 3) begin
                exp_wv = 1'b1;
                exp_wd = {fq[p+1], fq[p], fq[p-1], fq[p-2]};
                exp_wi = 5'(p / 4);
                if (!CK && p == 4 * n - 1) begin
                  exp_fd   = 1'b1;
                  in_frame = 1'b0;
                end
              end
            end else begin
              cs = 8'h00;
              for (int i = 0; i < fq.size() - 1; i++) cs ^= fq[i];
              if (cs == rx_data) exp_fd = 1'b1;
              else model_err(2'b10);
              in_frame = 1'b0;
            end
          end
        end
      end else if (in_frame) begin
        gap++;
        if (gap >= TO) model_err(2'b11);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("word_valid", 32'(word_valid), 32'(exp_wv));
      check("frame_done", 32'(frame_done), 32'(exp_fd));
      check("frame_err",  32'(frame_err),  32'(exp_fe));
      check("err_code",   32'(err_code),   32'(exp_ec));
      check("busy",       32'(busy),       32'(in_frame));
      check("word_data",  word_data,       exp_wd);
      check("word_index", 32'(word_index), 32'(exp_wi));
    end
  end

  // Entered and left one time unit after a rising edge; the tick is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int n, input bit corrupt, input int gmax);
    logic [7:0] cs, b;
    send_byte(8'hA5, int'($urandom_range(gmax, 0)));
    send_byte(8'(n), int'($urandom_range(gmax, 0)));
    cs = 8'(n);
    if (n >= 1 && n <= MAXW) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        if ($urandom_range(7, 0) == 0) b = 8'hA5;
        cs ^= b;
        send_byte(b, int'($urandom_range(gmax, 0)));
      end
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
      send_byte(corrupt ? (cs ^ 8'(1 + $urandom_range(254, 0))) : cs, 0);
`else
      if (corrupt) send_byte(8'h00, 0);
`endif
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset err_code", 32'(err_code), 32'd0);
    check("reset word_data", word_data, 32'd0);

    // Single-word frame with literal expectations.
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    check("lit word_valid", 32'(word_valid), 32'd1);
    check("lit word_data", word_data, 32'h1234_5678);
    check("lit word_index", 32'(word_index), 32'd0);
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
    send_byte(8'h09, 0);
`endif
    check("lit frame_done", 32'(frame_done), 32'd1);
    check("lit err_code kept", 32'(err_code), 32'd0);

    // Junk before header, then two words containing the header value as data.
    send_byte(8'h00, 0); send_byte(8'hFF, 1);
    check("lit junk ignored", 32'(busy), 32'd0);
    send_byte(8'hA5, 0); send_byte(8'h02, 0);
    repeat (4) send_byte(8'hA5, 0);
    check("lit w0 data", word_data, 32'hA5A5_A5A5);
    check("lit w0 index", 32'(word_index), 32'd0);
    repeat (4) send_byte(8'hFF, 0);
    check("lit w1 data", word_data, 32'hFFFF_FFFF);
    check("lit w1 index", 32'(word_index), 32'd1);
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
    send_byte(8'h02, 0);
`endif
    check("lit 2w frame_done", 32'(frame_done), 32'd1);

    // Count out of range, then recovery.
    send_byte(8'hA5, 0); send_byte(8'h21, 0);
    check("lit n33 frame_err", 32'(frame_err), 32'd1);
    check("lit n33 err_code", 32'(err_code), 32'd1);
    check("lit n33 busy", 32'(busy), 32'd0);
    send_frame(1, 1'b0, 0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0);
    check("lit n0 err_code", 32'(err_code), 32'd1);
    send_frame(MAXW, 1'b0, 1);

`ifdef DUMP_FRAME_RX_CHECKSUM_EN
    send_frame(2, 1'b1, 0);
    check("lit bad cs err", 32'(frame_err), 32'd1);
    check("lit bad cs code", 32'(err_code), 32'd2);
`endif

    // Timeout after silence.
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h22, TO - 1);
    check("lit pre-timeout err", 32'(frame_err), 32'd0);
    check("lit pre-timeout busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lit timeout err", 32'(frame_err), 32'd1);
    check("lit timeout code", 32'(err_code), 32'd3);
    check("lit timeout busy", 32'(busy), 32'd0);

    // A byte landing on the expiry cycle keeps the frame alive.
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h22, TO - 1);
    send_byte(8'h33, 0);
    check("lit tick wins err", 32'(frame_err), 32'd0);
    check("lit tick wins busy", 32'(busy), 32'd1);
    send_byte(8'h44, 0);
`ifdef DUMP_FRAME_RX_CHECKSUM_EN
    send_byte(8'h45, 0);
`endif
    check("lit tick wins done", 32'(frame_done), 32'd1);
    check("lit tick wins word", word_data, 32'h4433_2211);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    #2 reset = 1'b1;
    #1;
    check("lit rst busy", 32'(busy), 32'd0);
    check("lit rst word_data", word_data, 32'd0);
    check("lit rst err_code", 32'(err_code), 32'd0);
    check("lit rst strobes", 32'({word_valid, frame_done, frame_err}), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic checked every cycle by the model.
    for (int f = 0; f < 60; f++) begin
      int kind;
      kind = int'($urandom_range(9, 0));
      repeat ($urandom_range(2, 0)) send_byte(8'($urandom), int'($urandom_range(2, 0)));
      if (kind == 0) begin
        send_frame(int'($urandom_range(255, 33)), 1'b0, 1);
      end else if (kind == 1) begin
        send_byte(8'hA5, 0); send_byte(8'h03, 0);
        repeat ($urandom_range(5, 0)) send_byte(8'($urandom), 0);
        repeat (TO + 2) begin
          @(posedge clk); #1;
        end
      end else begin
        send_frame(int'($urandom_range(4, 1)), ($urandom_range(3, 0) == 0), 3);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_frame_rx.md
DUMP_FRAME_RX -- requirements
Module: dump_frame_rx

Interface
REQ-001 Parameter MAX_WORDS, default 32, SHALL be the maximum words per frame (one per register-file entry).
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL be the maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 rx_done_tick  input  1  SHALL be a one-cycle strobe from the UART receiver marking rx_data valid.
REQ-006 rx_data  input  8  SHALL be the received byte.
REQ-007 word_valid  output  1  SHALL be a one-cycle strobe marking word_data/word_index valid.
REQ-008 word_data  output  32  SHALL be the reassembled word.
REQ-009 word_index  output  clog2(MAX_WORDS)  SHALL be the word position in the frame, starting at 0.
REQ-010 frame_done  output  1  SHALL be a one-cycle strobe on good frame completion.
REQ-011 frame_err  output  1  SHALL be a one-cycle strobe on frame abort.
REQ-012 err_code  output  2  SHALL hold the last error cause: 01 bad count, 10 checksum mismatch, 11 timeout.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 Frame format SHALL be: header 0xA5, count byte N, N words of 4 bytes each, LSB first, then checksum byte.
REQ-015 States SHALL be IDLE, COUNT, WORD, CHECK.
REQ-016 In IDLE, byte 0xA5 SHALL move to COUNT; all other bytes SHALL be ignored with no output.
REQ-017 In COUNT, N=0 or N>MAX_WORDS SHALL pulse frame_err, set err_code=01 and return to IDLE; otherwise it SHALL latch N, clear byte/word counters, seed checksum=N and move to WORD.
REQ-018 In WORD, each byte SHALL shift into bits [8k+7:8k] for byte k=0..3 and be XORed into the checksum; 0xA5 inside the payload SHALL be treated as data.
REQ-019 word_valid SHALL pulse in the cycle after the 4th byte's tick, with word_data and word_index stable until the next word_valid.
REQ-020 After word N-1 the FSM SHALL move to CHECK.
REQ-021 In CHECK, received byte equal to checksum SHALL pulse frame_done; otherwise it SHALL pulse frame_err with err_code=10; both cases SHALL return to IDLE.
REQ-022 The timeout counter SHALL clear on every rx_done_tick and in IDLE, and increment otherwise.
REQ-023 When the counter reaches TIMEOUT_CYCLES-1 the block SHALL pulse frame_err, set err_code=11 and return to IDLE.
REQ-024 If rx_done_tick and timeout expiry coincide, the tick SHALL win and no timeout SHALL be raised.
REQ-025 A word already emitted SHALL NOT be retracted on a later error; consumers SHALL qualify the data with frame_done.
REQ-026 frame_done and frame_err SHALL never assert in the same cycle.

Reset
REQ-027 Reset SHALL force IDLE and clear word_valid, frame_done, frame_err, busy, word_data, word_index, err_code, all counters and the checksum.
REQ-028 Reset mid-frame SHALL discard the partial frame with no strobe.

Configuration
REQ-029 With DUMP_FRAME_RX_CHECKSUM_EN defined, CHECK SHALL exist and behave per REQ-021.
REQ-030 Without DUMP_FRAME_RX_CHECKSUM_EN, no checksum byte SHALL be expected: frame_done SHALL pulse together with the last word_valid, and err_code=10 SHALL never occur.

Structure
REQ-031 The shared debug package SHALL hold the header constant 0xA5, the error-code constants and the state-encoding typedef.
REQ-032 The inter-byte timeout SHALL be a sub-module, byte_timeout, with inputs clk, reset, clr, en and a one-cycle expire output.

Verification
REQ-033 Frame A5 01 78 56 34 12 checksum 0x09 -> word_valid with word_data=0x12345678 and word_index=0, then frame_done; err_code unchanged.
REQ-034 Bytes 00 FF then frame A5 02 with 2 words of 0xA5A5A5A5 and 0xFFFFFFFF, checksum 0x02 -> leading bytes ignored, two word_valid strobes with index 0 and 1, then frame_done.
REQ-035 A5 21 (N=33) -> frame_err with err_code=01 and busy low the next cycle; a following valid frame SHALL be accepted.
REQ-036 Valid frame with the checksum byte corrupted -> all words emitted, then frame_err with err_code=10.
REQ-037 A5 01 11 22 followed by silence for TIMEOUT_CYCLES -> frame_err with err_code=11; a tick landing on the expiry cycle -> no error.
REQ-038 Reset asserted after the 2nd payload byte -> outputs clear immediately and no strobe; build without the macro -> frame_done coincides with the last word_valid.
